dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL take parameter DW, default 16: data width of all data buses.
REQ-002 SHALL take parameter AW, default 16: address width of all address buses.
REQ-003 SHALL take parameter LOCK_MAX, default 4: maximum consecutive locked grants, range 1..7.
REQ-004 SHALL use one clock; reset is synchronous and active-high. Ports: clk input 1, rising-edge clock; rst input 1, synchronous active-high reset.
REQ-005 SHALL provide, for each requester x in {0,1}, these inputs: mx_req input 1, access request; mx_we input 1, 1=write 0=read; mx_lock input 1, hold ownership; mx_addr input AW, word address; mx_wdata input DW, write data.
REQ-006 SHALL provide, for each requester x, these outputs: mx_gnt output 1, access performed this cycle; mx_rvalid output 1, read data valid; mx_rdata output DW, returned read data.
REQ-007 SHALL provide the memory-side ports: mem_addr output AW; mem_wdata output DW; mem_write output 1; mem_read output 1; mem_rdata input DW, combinational read data from the data memory.

Function
REQ-008 SHALL grant at most one requester per cycle; mx_gnt is combinational from the current inputs and state, and the granted access completes in that same cycle.
REQ-009 SHALL drive the memory port from the granted requester: mem_addr=mx_addr, mem_wdata=mx_wdata, mem_write=mx_we, mem_read=~mx_we.
REQ-010 SHALL drive mem_addr, mem_wdata, mem_write and mem_read all to 0 in any cycle with no grant.
REQ-011 SHALL, for a granted read, register mem_rdata into mx_rdata at the end of the grant cycle and assert mx_rvalid for exactly the next cycle (latency 1).
REQ-012 SHALL hold mx_rdata between reads; mx_rvalid is 0 after a write or an idle cycle.
REQ-013 SHALL keep a last-grant pointer lp, updated on every grant.
REQ-014 SHALL arbitrate in state IDLE as follows: a single requester wins; on contention the requester != lp wins (round-robin).
REQ-015 SHALL use FSM states IDLE, OWN0 and OWN1, plus a lock counter cnt.
REQ-016 SHALL, from IDLE, move to OWNx with cnt=1 when winner x has mx_lock=1; otherwise it stays in IDLE.
REQ-017 SHALL, in OWNx with mx_req=1, mx_lock=1 and cnt<LOCK_MAX, grant x regardless of the other requester, increment cnt and remain in OWNx.
REQ-018 SHALL, in OWNx when REQ-017 does not hold, arbitrate that cycle per REQ-014 and REQ-016 with lp=x. On contention the other requester therefore wins; a sole requester x may re-lock with cnt=1.
REQ-019 SHALL not grant while rst=1.
REQ-020 SHALL not ignore the other requester's requests while one requester is locked: they wait, and no request is dropped or queued internally.

Reset
REQ-021 SHALL, on rst=1 at a clock edge, set state=IDLE, cnt=0, lp=1 (m0 wins the first contention), m0_rvalid=m1_rvalid=0 and m0_rdata=m1_rdata=0.
REQ-022 SHALL, when reset is asserted mid-lock or during a read's return cycle, abort the lock; no rvalid is issued after reset.

Configuration
REQ-023 SHALL support the macro DMEM_ARB_LOCK_EN. When defined, locking behaves per REQ-015..REQ-018.
REQ-024 SHALL, without DMEM_ARB_LOCK_EN, ignore m0_lock and m1_lock, keep the FSM in IDLE, and perform pure per-cycle round-robin.

Verification
REQ-025 SHALL cover single requester: m0 writes 0x1234 to addr 0x05, then reads 0x05 -> m0_gnt=1 both cycles, mem_write=1 first cycle, and m0_rvalid=1 with m0_rdata=0x1234 on the cycle after the read.
REQ-026 SHALL cover contention after reset: m0 and m1 request reads continuously -> grants alternate m0,m1,m0,m1, each read returns with 1-cycle latency to the correct port.
REQ-027 SHALL cover lock limit (macro on, LOCK_MAX=4): m0 requests locked writes continuously while m1 requests -> m0 granted 4 cycles, then m1 granted 1 cycle, then m0 locks again.
REQ-028 SHALL cover lock release: m0 locks for 2 cycles, then drops mx_lock while m1 requests -> the next cycle goes to m1 and the FSM returns to IDLE.
REQ-029 SHALL cover reset mid-operation: rst asserted during OWN0 on the cycle after a granted read -> no gnt during reset, m0_rvalid=0, and the first contention after reset goes to m0.
REQ-030 SHALL cover macro off: repeat the REQ-027 stimulus -> strict alternation m0,m1 each cycle.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-port data memory arbiter: round-robin on contention, single-cycle access,
// registered read return. Optional ownership locking when DMEM_ARB_LOCK_EN is defined.
module dmem_arbiter #(
  parameter int DW       = 16,
  parameter int AW       = 16,
  parameter int LOCK_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,

  input  logic          m0_req,
  input  logic          m0_we,
  input  logic          m0_lock,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,

  input  logic          m1_req,
  input  logic          m1_we,
  input  logic          m1_lock,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,

  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_write,
  output logic          mem_read,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  localparam logic [2:0] LOCK_CNT = 3'(LOCK_MAX);

  state_t        state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic          lp_q, lp_d;
  logic          rvalid0_q, rvalid0_d;
  logic          rvalid1_q, rvalid1_d;
  logic [DW-1:0] rdata0_q, rdata0_d;
  logic [DW-1:0] rdata1_q, rdata1_d;

  logic gnt0, gnt1;
  logic hold0, hold1;
  logic any_req, win1, win_lock;

`ifndef DMEM_ARB_LOCK_EN
  logic unused_lock;
  assign unused_lock = m0_lock ^ m1_lock;
`endif

  // Round-robin winner when no lock is held: the port other than lp wins a tie.
  assign any_req  = m0_req | m1_req;
  assign win1     = m1_req & (~m0_req | ~lp_q);
  assign win_lock = win1 ? m1_lock : m0_lock;

  always_comb begin
    hold0 = 1'b0;
    hold1 = 1'b0;
`ifdef DMEM_ARB_LOCK_EN
    hold0 = (state_q == OWN0) && m0_req && m0_lock && (cnt_q < LOCK_CNT);
    hold1 = (state_q == OWN1) && m1_req && m1_lock && (cnt_q < LOCK_CNT);
`endif
  end

  always_comb begin
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    state_d = state_q;
    cnt_d   = cnt_q;
    lp_d    = lp_q;
    if (rst) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (hold0) begin
      gnt0  = 1'b1;
      lp_d  = 1'b0;
      cnt_d = cnt_q + 3'd1;
    end else if (hold1) begin
      gnt1  = 1'b1;
      lp_d  = 1'b1;
      cnt_d = cnt_q + 3'd1;
    end else if (any_req) begin
      gnt0 = ~win1;
      gnt1 = win1;
      lp_d = win1;
`ifdef DMEM_ARB_LOCK_EN
      if (win_lock) begin
        state_d = win1 ? OWN1 : OWN0;
        cnt_d   = 3'd1;
      end else begin
        state_d = IDLE;
        cnt_d   = '0;
      end
`else
      state_d = IDLE;
      cnt_d   = '0;
`endif
    end else begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

`ifndef DMEM_ARB_LOCK_EN
  logic unused_win_lock;
  assign unused_win_lock = win_lock;
`endif

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_write = 1'b0;
    mem_read  = 1'b0;
    if (gnt0) begin
      mem_addr  = m0_addr;
      mem_wdata = m0_wdata;
      mem_write = m0_we;
      mem_read  = ~m0_we;
    end else if (gnt1) begin
      mem_addr  = m1_addr;
      mem_wdata = m1_wdata;
      mem_write = m1_we;
      mem_read  = ~m1_we;
    end
  end

  always_comb begin
    rvalid0_d = gnt0 & ~m0_we;
    rvalid1_d = gnt1 & ~m1_we;
    rdata0_d  = rvalid0_d ? mem_rdata : rdata0_q;
    rdata1_d  = rvalid1_d ? mem_rdata : rdata1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      lp_q      <= 1'b1;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      lp_q      <= lp_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
    end
  end

  // A return that lands in a reset cycle is suppressed so nothing leaks across reset.
  assign m0_gnt    = gnt0;
  assign m1_gnt    = gnt1;
  assign m0_rvalid = rvalid0_q & ~rst;
  assign m1_rvalid = rvalid1_q & ~rst;
  assign m0_rdata  = rdata0_q;
  assign m1_rdata  = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter; lock scenarios expect locking only when
// DMEM_ARB_LOCK_EN is defined, strict alternation otherwise.
module tb_dmem_arbiter;

  localparam int DW = 16;
  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          m0_req, m0_we, m0_lock;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata;
  logic          m0_gnt, m0_rvalid;
  logic [DW-1:0] m0_rdata;
  logic          m1_req, m1_we, m1_lock;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata;
  logic          m1_gnt, m1_rvalid;
  logic [DW-1:0] m1_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_write, mem_read;
  logic [DW-1:0] mem_rdata;

  logic [DW-1:0] mem [0:65535];

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_write) mem[mem_addr] <= mem_wdata;
  assign mem_rdata = mem[mem_addr];

  dmem_arbiter #(.DW(DW), .AW(AW), .LOCK_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write), .mem_read(mem_read),
    .mem_rdata(mem_rdata)
  );

  task automatic set_m0(input logic req, input logic we, input logic lock,
                        input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    m0_req = req; m0_we = we; m0_lock = lock; m0_addr = addr; m0_wdata = wdata;
  endtask

  task automatic set_m1(input logic req, input logic we, input logic lock,
                        input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    m1_req = req; m1_we = we; m1_lock = lock; m1_addr = addr; m1_wdata = wdata;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    set_m0(0, 0, 0, '0, '0);
    set_m1(0, 0, 0, '0, '0);
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_m0(1, 0, 0, 16'h0001, '0);
    set_m1(1, 1, 0, 16'h0002, 16'hFFFF);
    @(negedge clk);
    vectors++; if (m0_gnt !== 1'b0 || m1_gnt !== 1'b0) begin
      $display("FAIL reset_gnt: got m0=%b m1=%b expected 0 0", m0_gnt, m1_gnt); miscompares++; end
    vectors++; if (mem_read !== 1'b0 || mem_write !== 1'b0 || mem_addr !== '0) begin
      $display("FAIL reset_mem: got rd=%b wr=%b addr=%h expected 0 0 0", mem_read, mem_write, mem_addr); miscompares++; end
    next_cycle();
    rst = 1'b0;
    set_m0(0, 0, 0, '0, '0);
    set_m1(0, 0, 0, '0, '0);
    @(negedge clk);
    vectors++; if (m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0) begin
      $display("FAIL reset_rvalid: got %b %b expected 0 0", m0_rvalid, m1_rvalid); miscompares++; end
    vectors++; if (m0_rdata !== '0 || m1_rdata !== '0) begin
      $display("FAIL reset_rdata: got %h %h expected 0 0", m0_rdata, m1_rdata); miscompares++; end
    next_cycle();
  endtask

  task automatic test_single();
    set_m0(1, 1, 0, 16'h0005, 16'h1234);
    @(negedge clk);
    vectors++; if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin
      $display("FAIL single_wr_gnt: got %b %b expected 1 0", m0_gnt, m1_gnt); miscompares++; end
    vectors++; if (mem_write !== 1'b1 || mem_read !== 1'b0 || mem_addr !== 16'h0005 || mem_wdata !== 16'h1234) begin
      $display("FAIL single_wr_mem: got wr=%b rd=%b addr=%h wd=%h expected 1 0 0005 1234",
               mem_write, mem_read, mem_addr, mem_wdata); miscompares++; end
    next_cycle();
    set_m0(1, 0, 0, 16'h0005, 16'h0000);
    @(negedge clk);
    vectors++; if (m0_gnt !== 1'b1 || mem_read !== 1'b1 || mem_write !== 1'b0) begin
      $display("FAIL single_rd_gnt: got gnt=%b rd=%b wr=%b expected 1 1 0", m0_gnt, mem_read, mem_write); miscompares++; end
    vectors++; if (m0_rvalid !== 1'b0) begin
      $display("FAIL single_rvalid_after_wr: got %b expected 0", m0_rvalid); miscompares++; end
    next_cycle();
    set_m0(0, 0, 0, '0, '0);
    @(negedge clk);
    vectors++; if (m0_rvalid !== 1'b1 || m0_rdata !== 16'h1234) begin
      $display("FAIL single_rdata: got v=%b d=%h expected 1 1234", m0_rvalid, m0_rdata); miscompares++; end
    vectors++; if (mem_addr !== '0 || mem_read !== 1'b0 || mem_write !== 1'b0 || m0_gnt !== 1'b0) begin
      $display("FAIL single_idle_mem: got addr=%h rd=%b wr=%b gnt=%b expected 0", mem_addr, mem_read, mem_write, m0_gnt); miscompares++; end
    next_cycle();
    @(negedge clk);
    vectors++; if (m0_rvalid !== 1'b0 || m0_rdata !== 16'h1234) begin
      $display("FAIL single_hold: got v=%b d=%h expected 0 1234", m0_rvalid, m0_rdata); miscompares++; end
    next_cycle();
  endtask

  task automatic test_contention();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      if (i < 4) begin
        set_m0(1, 0, 0, 16'h0010 + 16'(i), '0);
        set_m1(1, 0, 0, 16'h0020 + 16'(i), '0);
      end else begin
        set_m0(0, 0, 0, '0, '0);
        set_m1(0, 0, 0, '0, '0);
      end
      @(negedge clk);
      if (i < 4) begin
        vectors++; if (m0_gnt !== (i % 2 == 0) || m1_gnt !== (i % 2 == 1)) begin
          $display("FAIL contention_gnt[%0d]: got %b %b expected %b %b", i, m0_gnt, m1_gnt,
                   (i % 2 == 0), (i % 2 == 1)); miscompares++; end
      end
      if (i > 0) begin
        if ((i - 1) % 2 == 0) begin
          vectors++; if (m0_rvalid !== 1'b1 || m1_rvalid !== 1'b0 || m0_rdata !== 16'hA000 + 16'(i - 1)) begin
            $display("FAIL contention_ret0[%0d]: got v0=%b v1=%b d=%h expected 1 0 %h", i, m0_rvalid, m1_rvalid,
                     m0_rdata, 16'hA000 + 16'(i - 1)); miscompares++; end
        end else begin
          vectors++; if (m1_rvalid !== 1'b1 || m0_rvalid !== 1'b0 || m1_rdata !== 16'hB000 + 16'(i - 1)) begin
            $display("FAIL contention_ret1[%0d]: got v1=%b v0=%b d=%h expected 1 0 %h", i, m1_rvalid, m0_rvalid,
                     m1_rdata, 16'hB000 + 16'(i - 1)); miscompares++; end
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_lock_limit();
    logic [7:0] exp_m0;
`ifdef DMEM_ARB_LOCK_EN
    exp_m0 = 8'b1110_1111;   // bit i = m0 granted in cycle i: 4 locked, m1, then m0 relocks
`else
    exp_m0 = 8'b0101_0101;
`endif
    do_reset();
    for (int i = 0; i < 8; i++) begin
      set_m0(1, 1, 1, 16'h0030, 16'h5000 + 16'(i));
      set_m1(1, 1, 0, 16'h0040, 16'h6000 + 16'(i));
      @(negedge clk);
      vectors++; if (m0_gnt !== exp_m0[i] || m1_gnt !== ~exp_m0[i] || mem_write !== 1'b1) begin
        $display("FAIL lock_limit[%0d]: got m0=%b m1=%b wr=%b expected %b %b 1", i, m0_gnt, m1_gnt,
                 mem_write, exp_m0[i], ~exp_m0[i]); miscompares++; end
      next_cycle();
    end
    set_m0(0, 0, 0, '0, '0);
    set_m1(0, 0, 0, '0, '0);
  endtask

  task automatic test_lock_release();
    logic [4:0] exp_m0;
    logic [4:0] lock_pat;
    lock_pat = 5'b00011;
`ifdef DMEM_ARB_LOCK_EN
    exp_m0 = 5'b01011;
`else
    exp_m0 = 5'b10101;
`endif
    do_reset();
    for (int i = 0; i < 5; i++) begin
      set_m0(1, 1, lock_pat[i], 16'h0050, 16'h7000 + 16'(i));
      set_m1(1, 1, 0, 16'h0060, 16'h8000 + 16'(i));
      @(negedge clk);
      vectors++; if (m0_gnt !== exp_m0[i] || m1_gnt !== ~exp_m0[i]) begin
        $display("FAIL lock_release[%0d]: got m0=%b m1=%b expected %b %b", i, m0_gnt, m1_gnt,
                 exp_m0[i], ~exp_m0[i]); miscompares++; end
      next_cycle();
    end
    set_m0(0, 0, 0, '0, '0);
    set_m1(0, 0, 0, '0, '0);
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_m0(1, 0, 1, 16'h0011, '0);
    set_m1(1, 0, 0, 16'h0021, '0);
    @(negedge clk);
    vectors++; if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin
      $display("FAIL rstmid_pre_gnt: got %b %b expected 1 0", m0_gnt, m1_gnt); miscompares++; end
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    vectors++; if (m0_gnt !== 1'b0 || m1_gnt !== 1'b0 || mem_read !== 1'b0) begin
      $display("FAIL rstmid_gnt: got %b %b rd=%b expected 0 0 0", m0_gnt, m1_gnt, mem_read); miscompares++; end
    vectors++; if (m0_rvalid !== 1'b0) begin
      $display("FAIL rstmid_rvalid_in_rst: got %b expected 0", m0_rvalid); miscompares++; end
    next_cycle();
    rst = 1'b0;
    set_m0(1, 0, 0, 16'h0012, '0);
    set_m1(1, 0, 0, 16'h0022, '0);
    @(negedge clk);
    vectors++; if (m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0) begin
      $display("FAIL rstmid_rvalid_after: got %b %b expected 0 0", m0_rvalid, m1_rvalid); miscompares++; end
    vectors++; if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin
      $display("FAIL rstmid_first_contention: got %b %b expected 1 0", m0_gnt, m1_gnt); miscompares++; end
    next_cycle();
    set_m0(0, 0, 0, '0, '0);
    set_m1(0, 0, 0, '0, '0);
    @(negedge clk);
    vectors++; if (m0_rvalid !== 1'b1 || m0_rdata !== 16'hA002) begin
      $display("FAIL rstmid_return: got v=%b d=%h expected 1 a002", m0_rvalid, m0_rdata); miscompares++; end
    next_cycle();
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = '0;
    for (int i = 0; i < 4; i++) begin
      mem[16'h0010 + i] = 16'hA000 + 16'(i);
      mem[16'h0020 + i] = 16'hB000 + 16'(i);
    end
    set_m0(0, 0, 0, '0, '0);
    set_m1(0, 0, 0, '0, '0);
    rst = 1'b1;
    #1;
    test_reset();
    test_single();
    test_contention();
    test_lock_limit();
    test_lock_release();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
